// File: rtl/adc_avg_pkg.sv
// Shared definitions for the ADC sample averager: FSM states, default
// window limit and the accumulator sizing rule.
package adc_avg_pkg;

  // Largest supported log2 window size (window up to 128 samples).
  localparam int MAX_SHIFT_DEF = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } avg_state_t;

  // Sum of 2^max_shift codes of w bits never needs more than w+max_shift bits.
  function automatic int acc_width(input int w, input int max_shift);
    return w + max_shift;
  endfunction

endpackage

// File: rtl/adc_avg_window_cmp.sv
// Window comparator with hysteresis on averaged ADC results. The set test
// is checked first so inverted thresholds cannot toggle within one update.
module adc_avg_window_cmp #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] result,
  input  logic         result_valid,
  input  logic [W-1:0] Thr_hi_i,
  input  logic [W-1:0] Thr_lo_i,
  output logic         Alarm_o
);

  // Alarm state: set above Thr_hi_i, clear below Thr_lo_i, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Alarm_o <= 1'b0;
    end else if (result_valid) begin
      if (result > Thr_hi_i) begin
        Alarm_o <= 1'b1;
      end else if (result < Thr_lo_i) begin
        Alarm_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/adc_sample_averager.sv
// Averages 2^k ADC codes with round-half-up and presents each result on a
// valid/ready output register; results arriving while the previous one is
// still unconsumed are dropped and flagged on the sticky Overrun_o.
module adc_sample_averager
  import adc_avg_pkg::*;
#(
  parameter int W         = 16,
  parameter int MAX_SHIFT = MAX_SHIFT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] On_counter_val,
  input  logic         ADC_valid_strb,
  input  logic [2:0]   Avg_shift_i,
  input  logic         Clear_i,
  input  logic         Avg_ready_i,
  input  logic [W-1:0] Thr_hi_i,
  input  logic [W-1:0] Thr_lo_i,
  output logic [W-1:0] Avg_val_o,
  output logic         Avg_valid_o,
  output logic         Overrun_o,
  output logic         Alarm_o
);

  localparam int ACC_W = acc_width(W, MAX_SHIFT);
  localparam int CNT_W = MAX_SHIFT + 1;
  localparam int KW    = (MAX_SHIFT < 2) ? 1 : $clog2(MAX_SHIFT + 1);

  avg_state_t       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] win_sz;
  logic [KW-1:0]    k_q;
  logic [KW-1:0]    k_in;
  logic [W-1:0]     flush_res;
  logic             flush_go;
  logic [W-1:0]     res_p1;
  logic             vld_p1;
  logic             xfer;

  // Round-half-up divide by 2^k; the extra bit keeps the rounding add exact.
  function automatic logic [W-1:0] round_shift(input logic [ACC_W-1:0] a,
                                               input logic [KW-1:0]    k);
    logic [ACC_W:0] t;
    t = {1'b0, a};
    if (k != '0) begin
      t = t + ((ACC_W+1)'(1) << (k - KW'(1)));
    end
    t = t >> k;
    return W'(t);
  endfunction

  // Requested window size, clamped to the supported maximum.
  always_comb begin
    k_in = KW'(Avg_shift_i);
    if (int'(Avg_shift_i) > MAX_SHIFT) begin
      k_in = KW'(MAX_SHIFT);
    end
  end

  assign cnt_nxt   = cnt + CNT_W'(1);
  assign win_sz    = CNT_W'(1) << k_q;
  assign flush_res = round_shift(acc, k_q);
  assign flush_go  = (state == FLUSH) && !Clear_i;
  assign xfer      = Avg_valid_o && Avg_ready_i;

  // Window FSM: a strobe in IDLE or FLUSH opens a new window and latches k.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      k_q   <= '0;
    end else if (Clear_i) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, FLUSH: begin
          if (ADC_valid_strb) begin
            k_q   <= k_in;
            acc   <= ACC_W'(On_counter_val);
            cnt   <= CNT_W'(1);
            state <= (k_in == '0) ? FLUSH : ACCUM;
          end else begin
            acc   <= '0;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        ACCUM: begin
          if (ADC_valid_strb) begin
            acc <= acc + ACC_W'(On_counter_val);
            cnt <= cnt_nxt;
            if (cnt_nxt == win_sz) begin
              state <= FLUSH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p1: rounded result leaves FLUSH ----
  // Valid for the registered flush result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= flush_go;
    end
  end

  // Flush result data; qualified by vld_p1 so it needs no reset.
  always_ff @(posedge clk) begin
    if (flush_go) begin
      res_p1 <= flush_res;
    end
  end

  // ---- stage p2: output register, handshake and overrun ----
  // Load a new result when the slot is free or being emptied; otherwise drop it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Avg_val_o   <= '0;
      Avg_valid_o <= 1'b0;
      Overrun_o   <= 1'b0;
    end else begin
      if (vld_p1 && (!Avg_valid_o || xfer)) begin
        Avg_val_o   <= res_p1;
        Avg_valid_o <= 1'b1;
      end else if (xfer) begin
        Avg_valid_o <= 1'b0;
      end
      if (Clear_i) begin
        Overrun_o <= 1'b0;
      end else if (vld_p1 && Avg_valid_o && !xfer) begin
        Overrun_o <= 1'b1;
      end
    end
  end

  adc_avg_window_cmp #(
    .W(W)
  ) u_window_cmp (
    .clk          (clk),
    .reset        (reset),
    .result       (res_p1),
    .result_valid (vld_p1),
    .Thr_hi_i     (Thr_hi_i),
    .Thr_lo_i     (Thr_lo_i),
    .Alarm_o      (Alarm_o)
  );

endmodule

// File: tb/tb_adc_sample_averager.sv
// Bench for adc_sample_averager: directed scenarios plus a randomized run
// compared against an arithmetic average/alarm model.
module tb_adc_sample_averager;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] On_counter_val = '0;
  logic         ADC_valid_strb = 1'b0;
  logic [2:0]   Avg_shift_i = '0;
  logic         Clear_i = 1'b0;
  logic         Avg_ready_i = 1'b0;
  logic [W-1:0] Thr_hi_i = '1;
  logic [W-1:0] Thr_lo_i = '0;
  logic [W-1:0] Avg_val_o;
  logic         Avg_valid_o;
  logic         Overrun_o;
  logic         Alarm_o;

  int checks = 0;
  int errors = 0;

  logic        mon_en = 1'b0;
  int unsigned obs_val_q[$];
  logic        obs_alm_q[$];

  adc_sample_averager #(.W(W), .MAX_SHIFT(7)) dut (
    .clk            (clk),
    .reset          (reset),
    .On_counter_val (On_counter_val),
    .ADC_valid_strb (ADC_valid_strb),
    .Avg_shift_i    (Avg_shift_i),
    .Clear_i        (Clear_i),
    .Avg_ready_i    (Avg_ready_i),
    .Thr_hi_i       (Thr_hi_i),
    .Thr_lo_i       (Thr_lo_i),
    .Avg_val_o      (Avg_val_o),
    .Avg_valid_o    (Avg_valid_o),
    .Overrun_o      (Overrun_o),
    .Alarm_o        (Alarm_o)
  );

  always #5 clk = ~clk;

  // Record every result the consumer actually takes.
  always @(negedge clk) begin
    if (mon_en && Avg_valid_o && Avg_ready_i) begin
      obs_val_q.push_back(int'(Avg_val_o));
      obs_alm_q.push_back(Alarm_o);
    end
  end

  // Mean of 2^k samples, rounded half up.
  function automatic int unsigned ref_avg(input longint unsigned sum, input int k);
    longint unsigned r;
    if (k > 0) r = (sum + (64'd1 << (k - 1))) >> k;
    else       r = sum;
    return int'(r % 65536);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_sample(input logic [W-1:0] v);
    On_counter_val = v;
    ADC_valid_strb = 1'b1;
    @(posedge clk);
    #1;
    ADC_valid_strb = 1'b0;
  endtask

  task automatic do_reset();
    ADC_valid_strb = 1'b0;
    Clear_i        = 1'b0;
    reset          = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    step(2);
    checks++; if (Avg_val_o !== 16'd0) begin errors++; $display("FAIL rst_val got %0d want 0", Avg_val_o); end
    checks++; if (Avg_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", Avg_valid_o); end
    checks++; if (Overrun_o !== 1'b0) begin errors++; $display("FAIL rst_overrun got %0b want 0", Overrun_o); end
    checks++; if (Alarm_o !== 1'b0) begin errors++; $display("FAIL rst_alarm got %0b want 0", Alarm_o); end
    reset = 1'b1;
    step(3);
    checks++; if (Avg_valid_o !== 1'b0) begin errors++; $display("FAIL rst_idle_valid got %0b want 0", Avg_valid_o); end
  endtask

  task automatic test_basic_k2();
    int unsigned smp[4] = '{100, 101, 102, 103};
    longint unsigned sum = 0;
    do_reset();
    Avg_ready_i = 1'b1;
    Avg_shift_i = 3'd2;
    for (int i = 0; i < 4; i++) begin
      sum += smp[i];
      drive_sample(16'(smp[i]));
      if (i < 3) step(7);
    end
    @(negedge clk);
    checks++; if (Avg_valid_o !== 1'b0) begin errors++; $display("FAIL basic_lat_e1 got %0b want 0", Avg_valid_o); end
    @(negedge clk);
    checks++; if (Avg_valid_o !== 1'b0) begin errors++; $display("FAIL basic_lat_e2 got %0b want 0", Avg_valid_o); end
    @(negedge clk);
    checks++; if (Avg_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", Avg_valid_o); end
    checks++; if (Avg_val_o !== 16'(ref_avg(sum, 2))) begin errors++; $display("FAIL basic_val got %0d want %0d", Avg_val_o, ref_avg(sum, 2)); end
    @(negedge clk);
    checks++; if (Avg_valid_o !== 1'b0) begin errors++; $display("FAIL basic_pulse got %0b want 0", Avg_valid_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_k0_and_k7();
    int unsigned smp[2] = '{7, 65535};
    longint unsigned sum = 0;
    do_reset();
    Avg_ready_i = 1'b1;
    Avg_shift_i = 3'd0;
    for (int i = 0; i < 2; i++) begin
      drive_sample(16'(smp[i]));
      @(negedge clk);
      @(negedge clk);
      checks++; if (Avg_valid_o !== 1'b0) begin errors++; $display("FAIL k0_early_%0d got %0b want 0", i, Avg_valid_o); end
      @(negedge clk);
      checks++; if (Avg_valid_o !== 1'b1 || Avg_val_o !== 16'(smp[i])) begin
        errors++; $display("FAIL k0_res_%0d got %0b/%0d want 1/%0d", i, Avg_valid_o, Avg_val_o, smp[i]);
      end
      @(posedge clk); #1;
      step(3);
    end
    Avg_shift_i = 3'd7;
    for (int i = 0; i < 128; i++) begin
      sum += 65535;
      drive_sample(16'hFFFF);
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++; if (Avg_valid_o !== 1'b1 || Avg_val_o !== 16'(ref_avg(sum, 7))) begin
      errors++; $display("FAIL k7_full got %0b/%0d want 1/%0d", Avg_valid_o, Avg_val_o, ref_avg(sum, 7));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overrun();
    int unsigned smp[6] = '{10, 11, 20, 21, 30, 31};
    int unsigned first;
    do_reset();
    Avg_ready_i = 1'b0;
    Avg_shift_i = 3'd1;
    first = ref_avg(longint'(smp[0] + smp[1]), 1);
    for (int i = 0; i < 6; i++) begin
      drive_sample(16'(smp[i]));
      step(4);
      if (i == 1) begin
        checks++; if (Overrun_o !== 1'b0 || Avg_val_o !== 16'(first)) begin
          errors++; $display("FAIL ovr_first got ovr=%0b val=%0d want 0/%0d", Overrun_o, Avg_val_o, first);
        end
      end
      if (i == 3) begin
        checks++; if (Overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_set got %0b want 1", Overrun_o); end
      end
    end
    checks++; if (Avg_val_o !== 16'(first) || Avg_valid_o !== 1'b1) begin
      errors++; $display("FAIL ovr_hold got %0d/%0b want %0d/1", Avg_val_o, Avg_valid_o, first);
    end
    Clear_i = 1'b1;
    step(1);
    Clear_i = 1'b0;
    checks++; if (Overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_clear got %0b want 0", Overrun_o); end
    checks++; if (Avg_valid_o !== 1'b1) begin errors++; $display("FAIL ovr_clear_valid got %0b want 1", Avg_valid_o); end
    Avg_ready_i = 1'b1;
    step(1);
    Avg_ready_i = 1'b0;
    checks++; if (Avg_valid_o !== 1'b0 || Avg_val_o !== 16'(first)) begin
      errors++; $display("FAIL ovr_consume got %0b/%0d want 0/%0d", Avg_valid_o, Avg_val_o, first);
    end
  endtask

  task automatic test_alarm();
    int unsigned smp[5] = '{500, 650, 500, 350, 500};
    logic alm = 1'b0;
    do_reset();
    Avg_ready_i = 1'b1;
    Avg_shift_i = 3'd0;
    Thr_hi_i    = 16'd600;
    Thr_lo_i    = 16'd400;
    for (int i = 0; i < 5; i++) begin
      if (smp[i] > 600) alm = 1'b1;
      else if (smp[i] < 400) alm = 1'b0;
      drive_sample(16'(smp[i]));
      step(4);
      checks++; if (Alarm_o !== alm) begin errors++; $display("FAIL alarm_%0d got %0b want %0b", i, Alarm_o, alm); end
    end
  endtask

  task automatic test_clear();
    do_reset();
    Avg_ready_i = 1'b0;
    Avg_shift_i = 3'd2;
    Thr_hi_i    = 16'd0;
    Thr_lo_i    = 16'd0;
    drive_sample(16'd1000);
    step(1);
    drive_sample(16'd2000);
    step(1);
    Clear_i = 1'b1;
    drive_sample(16'd3000);
    Clear_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_sample(16'd4);
      step(4);
      if (i == 2) begin
        checks++; if (Avg_valid_o !== 1'b0) begin errors++; $display("FAIL clr_stale got %0b want 0", Avg_valid_o); end
      end
    end
    checks++; if (Avg_valid_o !== 1'b1 || Avg_val_o !== 16'(ref_avg(16, 2))) begin
      errors++; $display("FAIL clr_result got %0b/%0d want 1/%0d", Avg_valid_o, Avg_val_o, ref_avg(16, 2));
    end
    checks++; if (Alarm_o !== 1'b1) begin errors++; $display("FAIL clr_alarm got %0b want 1", Alarm_o); end
    drive_sample(16'd9);
    step(1);
    drive_sample(16'd9);
    reset = 1'b0;
    #2;
    checks++; if (Avg_val_o !== 16'd0 || Avg_valid_o !== 1'b0 || Overrun_o !== 1'b0 || Alarm_o !== 1'b0) begin
      errors++; $display("FAIL async_rst got val=%0d vld=%0b ovr=%0b alm=%0b want all 0", Avg_val_o, Avg_valid_o, Overrun_o, Alarm_o);
    end
    step(1);
    reset = 1'b1;
    step(1);
    for (int i = 0; i < 4; i++) begin
      drive_sample(16'd8);
      step(1);
    end
    step(3);
    checks++; if (Avg_valid_o !== 1'b1 || Avg_val_o !== 16'(ref_avg(32, 2))) begin
      errors++; $display("FAIL post_rst got %0b/%0d want 1/%0d", Avg_valid_o, Avg_val_o, ref_avg(32, 2));
    end
  endtask

  task automatic test_shift_change();
    do_reset();
    Avg_ready_i = 1'b0;
    Avg_shift_i = 3'd2;
    drive_sample(16'd40);
    Avg_shift_i = 3'd0;
    drive_sample(16'd41);
    step(2);
    drive_sample(16'd42);
    step(3);
    checks++; if (Avg_valid_o !== 1'b0) begin errors++; $display("FAIL shift_early got %0b want 0", Avg_valid_o); end
    drive_sample(16'd43);
    step(4);
    checks++; if (Avg_valid_o !== 1'b1 || Avg_val_o !== 16'(ref_avg(166, 2))) begin
      errors++; $display("FAIL shift_win got %0b/%0d want 1/%0d", Avg_valid_o, Avg_val_o, ref_avg(166, 2));
    end
    Avg_ready_i = 1'b1;
    step(1);
    Avg_ready_i = 1'b0;
    drive_sample(16'd77);
    step(4);
    checks++; if (Avg_valid_o !== 1'b1 || Avg_val_o !== 16'd77) begin
      errors++; $display("FAIL shift_next got %0b/%0d want 1/77", Avg_valid_o, Avg_val_o);
    end
  endtask

  task automatic test_random();
    int unsigned exp_val_q[$];
    logic        exp_alm_q[$];
    logic        alm = 1'b0;
    int unsigned hi, lo, v, r;
    int          k, n;
    longint unsigned sum;
    do_reset();
    hi = $urandom_range(45000, 20000);
    lo = $urandom_range(hi, 10000);
    Thr_hi_i    = 16'(hi);
    Thr_lo_i    = 16'(lo);
    Avg_ready_i = 1'b1;
    obs_val_q.delete();
    obs_alm_q.delete();
    mon_en = 1'b1;
    for (int w = 0; w < 30; w++) begin
      k = (w % 10 == 9) ? 7 : int'($urandom_range(4, 0));
      Avg_shift_i = 3'(k);
      sum = 0;
      for (int s = 0; s < (1 << k); s++) begin
        v = $urandom_range(65535, 0);
        sum += v;
        drive_sample(16'(v));
        if (s == 0) Avg_shift_i = 3'($urandom_range(7, 0));
        step(int'($urandom_range(2, 0)));
      end
      r = ref_avg(sum, k);
      if (r > hi) alm = 1'b1;
      else if (r < lo) alm = 1'b0;
      exp_val_q.push_back(r);
      exp_alm_q.push_back(alm);
    end
    step(6);
    mon_en = 1'b0;
    n = (obs_val_q.size() < exp_val_q.size()) ? obs_val_q.size() : exp_val_q.size();
    checks++; if (obs_val_q.size() != exp_val_q.size()) begin
      errors++; $display("FAIL rnd_count got %0d want %0d", obs_val_q.size(), exp_val_q.size());
    end
    for (int i = 0; i < n; i++) begin
      checks++; if (obs_val_q[i] !== exp_val_q[i]) begin
        errors++; $display("FAIL rnd_val_%0d got %0d want %0d", i, obs_val_q[i], exp_val_q[i]);
      end
      checks++; if (obs_alm_q[i] !== exp_alm_q[i]) begin
        errors++; $display("FAIL rnd_alarm_%0d got %0b want %0b", i, obs_alm_q[i], exp_alm_q[i]);
      end
    end
    checks++; if (Overrun_o !== 1'b0) begin errors++; $display("FAIL rnd_overrun got %0b want 0", Overrun_o); end
  endtask

  initial begin
    test_reset();
    test_basic_k2();
    test_k0_and_k7();
    test_overrun();
    test_alarm();
    test_clear();
    test_shift_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_sample_averager.md
Name: adc_sample_averager

Overview:
- Downstream consumer of the delta ADC stage.
- Takes the ADC conversion code (On_counter_val) qualified by ADC_valid_strb.
- Averages a runtime-selectable window of 2^k samples with round-half-up.
- Presents each result on a valid/ready output register, flags dropped results, and drives a window-comparator alarm with hysteresis for the control logic.

Parameters:
- W, 16, width of ADC code, average output and thresholds.
- MAX_SHIFT, 7, maximum log2 window size (window up to 128 samples).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- On_counter_val  in  W  ADC code from the delta ADC stage.
- ADC_valid_strb  in  1  one-cycle strobe; On_counter_val is valid this cycle.
- Avg_shift_i  in  3  log2 window size k, 0..MAX_SHIFT; values above MAX_SHIFT clamp to MAX_SHIFT.
- Clear_i  in  1  synchronous: discard the partial window and clear Overrun_o.
- Avg_ready_i  in  1  consumer ready.
- Thr_hi_i  in  W  alarm set threshold.
- Thr_lo_i  in  W  alarm clear threshold.
- Avg_val_o  out  W  averaged code.
- Avg_valid_o  out  1  Avg_val_o holds an unconsumed result.
- Overrun_o  out  1  sticky: a result was dropped.
- Alarm_o  out  1  window alarm.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: Avg_val_o=0, Avg_valid_o=0, Overrun_o=0, Alarm_o=0.
  - Internal: acc=0, cnt=0, FSM=IDLE, latched shift=0.
- Accumulator is W+MAX_SHIFT bits. Sample count is MAX_SHIFT+1 bits. Overflow of either is impossible by construction.
- FSM states:
  - IDLE: acc=0, no samples yet. On strobe: latch k=Avg_shift_i, acc<=sample, cnt<=1. If 2^k==1, go to FLUSH; else go to ACCUM.
  - ACCUM: on strobe, acc<=acc+sample, cnt<=cnt+1. When cnt+1==2^k, go to FLUSH. With no strobe, hold.
  - FLUSH (exactly one cycle): compute res=(acc + (k>0 ? 2^(k-1) : 0)) >> k, truncated to W bits. The result always fits in W bits (max 65535 for k=7). Hand res to the output stage. Go to IDLE.
    - A strobe arriving while in FLUSH is the first sample of the next window: acc<=sample, cnt<=1, k relatched, next state ACCUM (or FLUSH if k==0).
- Avg_shift_i is sampled only at window start; changes mid-window are ignored.
- Latency: the last sample is taken at edge t; FLUSH runs during cycle t..t+1; Avg_val_o and Avg_valid_o update at edge t+2.
- Output handshake:
  - A transfer occurs on any edge with Avg_valid_o=1 and Avg_ready_i=1.
  - New result, no pending valid (or pending valid transferring this same edge): load Avg_val_o; Avg_valid_o=1.
  - New result while Avg_valid_o=1 and not transferring: drop the new result, keep the old value, set Overrun_o=1.
  - Transfer with no new result: Avg_valid_o<=0. Avg_val_o holds its last value.
- Clear_i:
  - acc<=0, cnt<=0, FSM<=IDLE, Overrun_o<=0.
  - Avg_val_o, Avg_valid_o and Alarm_o are unaffected.
  - Clear_i with a strobe: clear wins; the sample is discarded.
  - Clear_i during FLUSH: the result is discarded.
  - Clear_i in the same cycle as an overrun event: Overrun_o ends 0.
- Alarm (sub-module), evaluated on every FLUSH result, including dropped ones:
  - res > Thr_hi_i: Alarm_o<=1.
  - else res < Thr_lo_i: Alarm_o<=0.
  - else hold.
  - The set check has priority, so a misconfigured Thr_lo_i > Thr_hi_i cannot oscillate within one update.
  - Alarm_o updates on the same edge as Avg_val_o would.
- reset asserted mid-window: everything returns to reset values immediately. The first window after reset deassertion starts at the next strobe.

Decomposition:
- Shared package adc_avg_pkg:
  - FSM state enum {IDLE, ACCUM, FLUSH}.
  - MAX_SHIFT default constant.
  - Accumulator width function W+MAX_SHIFT.
- One sub-module, adc_avg_window_cmp: inputs clk, reset, result, result_valid, Thr_hi_i, Thr_lo_i; output Alarm_o with hysteresis.
- FSM, accumulator and output register stay in the top module.

Test Plan:
- k=2, Avg_ready_i=1, samples 100,101,102,103 strobed every 8 cycles -> single Avg_valid_o pulse, Avg_val_o=102 (406+2>>2), valid 2 edges after the 4th strobe.
- k=0, samples 7,65535 -> two results, 7 then 65535, each 2 edges after its strobe; k=7 with 128 samples of 65535 -> 65535, no wrap.
- k=1, Avg_ready_i=0, samples 10,11,20,21,30,31 -> Avg_val_o stays 11 ((21+1)>>1), Overrun_o=1 after the 2nd result; Clear_i pulse -> Overrun_o=0, Avg_valid_o still 1; Avg_ready_i=1 for one cycle -> Avg_valid_o=0.
- Thr_hi=600, Thr_lo=400, k=0, samples 500,650,500,350,500 -> Alarm_o 0,1,1,0,0.
- k=2, two samples then Clear_i together with a 3rd strobe, then samples 4,4,4,4 -> result 4; earlier samples have no effect. Repeat with reset=0 mid-window -> all outputs 0 immediately.
- Avg_shift_i changed from 2 to 0 after the first sample of a window -> window still completes after 4 samples; the next window uses k=0.
